// File: rtl/muldiv_sequencer_if.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_if
//
// Purpose: bundles the request/response signals between the CPU control unit
// and the multi-cycle MUL/DIV sequencer.
//
// Signals:
//   start        request strobe from the control unit (sampled only in IDLE)
//   op           0 = signed MUL, 1 = signed DIV
//   a, b         operands (multiplicand/dividend, multiplier/divisor)
//   busy         sequencer is iterating; control unit stalls on it
//   done         one-cycle completion pulse; hi/lo/flags are valid with it
//   hi, lo       result halves (MUL: product, DIV: remainder/quotient)
//   div_by_zero  DIV with b == 0
//   err          unsupported operation
//
// Modports: master = control unit side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  logic             err;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero, err
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Purpose: multi-cycle controller and iterative datapath for the CPU's MUL/DIV
// instructions. A radix-2 Booth multiply or a signed restoring divide runs for
// WIDTH iterations, followed by one fix-up cycle and a one-cycle done pulse.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    muldiv_sequencer_if.slave (start/op/a/b in; busy/done/hi/lo/
//          div_by_zero/err out)
//
// Configuration:
//   MULDIV_DIV_EN  when defined, the divide path (restoring divide, divide-by-
//                  zero handling, sign correction) is compiled in. When
//                  undefined, op=1 completes immediately with err=1, hi/lo keep
//                  their previous values and div_by_zero is tied low.
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  // accA holds the Booth accumulator A, or the divide remainder R.
  logic [WIDTH:0]   accA_q, accA_d;
  // accQ holds the Booth multiplier Q, or the divide quotient Q.
  logic [WIDTH-1:0] accQ_q, accQ_d;
  logic             q1_q, q1_d;
  // operandM holds the sign-extended multiplicand, or |b| for divide.
  logic [WIDTH:0]   operandM_q, operandM_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   boothSum;
`ifdef MULDIV_DIV_EN
  logic             isDiv_q, isDiv_d;
  logic             signA_q, signA_d;
  logic             signB_q, signB_d;
  logic             divByZero_q, divByZero_d;
  logic [WIDTH:0]   divShift;
  logic [WIDTH:0]   divDiff;
`endif

  // State and datapath registers. Reset aborts any operation in flight and
  // clears every result and working register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      accA_q      <= '0;
      accQ_q      <= '0;
      q1_q        <= 1'b0;
      operandM_q  <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      err_q       <= 1'b0;
`ifdef MULDIV_DIV_EN
      isDiv_q     <= 1'b0;
      signA_q     <= 1'b0;
      signB_q     <= 1'b0;
      divByZero_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      accA_q      <= accA_d;
      accQ_q      <= accQ_d;
      q1_q        <= q1_d;
      operandM_q  <= operandM_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      err_q       <= err_d;
`ifdef MULDIV_DIV_EN
      isDiv_q     <= isDiv_d;
      signA_q     <= signA_d;
      signB_q     <= signB_d;
      divByZero_q <= divByZero_d;
`endif
    end
  end

  // Next-state and datapath logic. On accept the operands are loaded for a
  // multiply by default; the divide and early-completion cases then override.
  // RUN performs one iteration per cycle and FIX forms the final HI/LO, which
  // are only written on the way into DONE.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    accA_d      = accA_q;
    accQ_d      = accQ_q;
    q1_d        = q1_q;
    operandM_d  = operandM_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    err_d       = err_q;
    boothSum    = accA_q;
`ifdef MULDIV_DIV_EN
    isDiv_d     = isDiv_q;
    signA_d     = signA_q;
    signB_d     = signB_q;
    divByZero_d = divByZero_q;
    divShift    = '0;
    divDiff     = '0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = RUN;
          count_d    = CW'(WIDTH - 1);
          accA_d     = '0;
          accQ_d     = bus.b;
          q1_d       = 1'b0;
          operandM_d = {bus.a[WIDTH-1], bus.a};
          err_d      = 1'b0;
`ifdef MULDIV_DIV_EN
          isDiv_d     = bus.op;
          divByZero_d = 1'b0;
          if (bus.op) begin
            if (bus.b == '0) begin
              state_d     = DONE;
              divByZero_d = 1'b1;
              hi_d        = bus.a;
              lo_d        = '1;
            end else begin
              signA_d    = bus.a[WIDTH-1];
              signB_d    = bus.b[WIDTH-1];
              accQ_d     = bus.a[WIDTH-1] ? -bus.a : bus.a;
              operandM_d = {1'b0, (bus.b[WIDTH-1] ? -bus.b : bus.b)};
            end
          end
`else
          if (bus.op) begin
            state_d = DONE;
            err_d   = 1'b1;
          end
`endif
        end
      end

      RUN: begin
        // Booth step: add/subtract M per {Q[0], q_1}, then arithmetic shift
        // of the whole {A, Q, q_1} register.
        case ({accQ_q[0], q1_q})
          2'b10:   boothSum = accA_q - operandM_q;
          2'b01:   boothSum = accA_q + operandM_q;
          default: boothSum = accA_q;
        endcase
        accA_d = {boothSum[WIDTH], boothSum[WIDTH:1]};
        accQ_d = {boothSum[0], accQ_q[WIDTH-1:1]};
        q1_d   = accQ_q[0];
`ifdef MULDIV_DIV_EN
        // Restoring step. R < |b| <= 2^(WIDTH-1), so the shifted remainder
        // never reaches bit WIDTH and that bit of the difference is the sign.
        if (isDiv_q) begin
          divShift = {accA_q[WIDTH-1:0], accQ_q[WIDTH-1]};
          divDiff  = divShift - operandM_q;
          if (!divDiff[WIDTH]) begin
            accA_d = divDiff;
            accQ_d = {accQ_q[WIDTH-2:0], 1'b1};
          end else begin
            accA_d = divShift;
            accQ_d = {accQ_q[WIDTH-2:0], 1'b0};
          end
          q1_d = 1'b0;
        end
`endif
        if (count_q == '0) begin
          state_d = FIX;
        end else begin
          count_d = count_q - CW'(1);
        end
      end

      FIX: begin
        state_d = DONE;
        hi_d    = accA_q[WIDTH-1:0];
        lo_d    = accQ_q;
`ifdef MULDIV_DIV_EN
        // Quotient sign is the XOR of operand signs; remainder follows the
        // dividend. -2^(W-1) / -1 wraps naturally to 0x80..0.
        if (isDiv_q) begin
          lo_d = (signA_q ^ signB_q) ? -accQ_q : accQ_q;
          hi_d = signA_q ? -accA_q[WIDTH-1:0] : accA_q[WIDTH-1:0];
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q == RUN) || (state_q == FIX);
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.err  = err_q;
`ifdef MULDIV_DIV_EN
  assign bus.div_by_zero = divByZero_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Purpose: self-checking bench for muldiv_sequencer. Directed cases cover the
// signed multiply corners, signed divide corners, divide by zero, ignored
// start pulses during RUN and reset mid-operation; a randomized loop follows.
// Expected results come from plain 64-bit signed arithmetic.
//
// Honours MULDIV_DIV_EN the same way as the design: without it, op=1 is
// expected to complete immediately with err=1 and hi/lo unchanged.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 100;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  int checkCount = 0;
  int errorCount = 0;

  // Last result the control unit would hold in its HI/LO registers.
  logic [WIDTH-1:0] modelHi = '0;
  logic [WIDTH-1:0] modelLo = '0;

  muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point; every check goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model: signed arithmetic on 64-bit integers. Also predicts the
  // completion latency and number of busy cycles.
  task automatic modelOp(input logic op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] expHi, output logic [WIDTH-1:0] expLo,
                         output logic expDbz, output logic expErr,
                         output int expLat, output int expBusy);
    longint sa, sb, prod, quo, rem;
    sa      = longint'($signed(a));
    sb      = longint'($signed(b));
    expDbz  = 1'b0;
    expErr  = 1'b0;
    expLat  = WIDTH + 2;
    expBusy = WIDTH + 1;
    expHi   = modelHi;
    expLo   = modelLo;
    if (op == 1'b0) begin
      prod  = sa * sb;
      expHi = prod[63:32];
      expLo = prod[31:0];
    end else if (!DIV_EN) begin
      expErr  = 1'b1;
      expLat  = 1;
      expBusy = 0;
    end else if (b == '0) begin
      expDbz  = 1'b1;
      expHi   = a;
      expLo   = '1;
      expLat  = 1;
      expBusy = 0;
    end else begin
      quo   = sa / sb;
      rem   = sa % sb;
      expHi = rem[31:0];
      expLo = quo[31:0];
    end
    modelHi = expHi;
    modelLo = expLo;
  endtask

  // Issues one request, scrambles the operand inputs after the accept edge,
  // optionally pulses start again at cycle glitchCycle, and waits (bounded)
  // for done. lat counts cycles after the accept edge until done is seen.
  task automatic applyStimulus(input logic op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input int glitchCycle,
                               output int lat, output int busyCnt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    lat       = 0;
    busyCnt   = 0;
    while (lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busyCnt++;
      if (bus.done) break;
      if (lat == glitchCycle) begin
        bus.start = 1'b1;
        bus.op    = $urandom_range(0, 1);
        bus.a     = $urandom;
        bus.b     = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  // Runs one operation and compares everything observable against the model.
  task automatic runAndCheck(input string tag, input logic op,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input int glitchCycle);
    logic [WIDTH-1:0] expHi, expLo;
    logic expDbz, expErr;
    int expLat, expBusy, lat, busyCnt;
    modelOp(op, a, b, expHi, expLo, expDbz, expErr, expLat, expBusy);
    applyStimulus(op, a, b, glitchCycle, lat, busyCnt);
    checkOutput({tag, ".latency"}, lat, expLat);
    checkOutput({tag, ".busyCycles"}, busyCnt, expBusy);
    checkOutput({tag, ".hi"}, bus.hi, expHi);
    checkOutput({tag, ".lo"}, bus.lo, expLo);
    checkOutput({tag, ".divByZero"}, bus.div_by_zero, expDbz);
    checkOutput({tag, ".err"}, bus.err, expErr);
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, bus.done, 1'b0);
  endtask

  function automatic logic [WIDTH-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Main sequence: reset state, directed corners, reset abort, random loop.
  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", bus.busy, 1'b0);
    checkOutput("reset.done", bus.done, 1'b0);
    checkOutput("reset.hi", bus.hi, '0);
    checkOutput("reset.lo", bus.lo, '0);
    checkOutput("reset.divByZero", bus.div_by_zero, 1'b0);
    checkOutput("reset.err", bus.err, 1'b0);
    reset = 1'b1;

    runAndCheck("mul7xm3", 1'b0, 32'd7, 32'hFFFF_FFFD, 0);
    runAndCheck("mulMinxMin", 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    runAndCheck("mulMinx1", 1'b0, 32'h8000_0000, 32'd1, 0);
    runAndCheck("divm7x2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    runAndCheck("div7xm2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    runAndCheck("div5x0", 1'b1, 32'd5, 32'd0, 0);
    runAndCheck("divMinxm1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    runAndCheck("mul3x4Glitch", 1'b0, 32'd3, 32'd4, 5);

    // Reset asserted at RUN iteration 10 must abort with no done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("abort.busyBefore", bus.busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort.busy", bus.busy, 1'b0);
    checkOutput("abort.done", bus.done, 1'b0);
    checkOutput("abort.hi", bus.hi, '0);
    checkOutput("abort.lo", bus.lo, '0);
    checkOutput("abort.divByZero", bus.div_by_zero, 1'b0);
    checkOutput("abort.err", bus.err, 1'b0);
    modelHi = '0;
    modelLo = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort.noDone", bus.done, 1'b0);
    end
    reset = 1'b1;
    runAndCheck("postReset3x4", 1'b0, 32'd3, 32'd4, 0);

    runAndCheck("div9x3", 1'b1, 32'd9, 32'd3, 0);
    runAndCheck("mul6x7", 1'b0, 32'd6, 32'd7, 0);

    for (int i = 0; i < 24; i++) begin
      logic rop;
      logic [WIDTH-1:0] ra, rb;
      rop = ($urandom_range(0, 2) == 0);
      ra  = pickOperand();
      rb  = pickOperand();
      runAndCheck($sformatf("rand%0d", i), rop, ra, rb,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
